// File: rtl/memoria_32.sv
// Byte-organised RAM with separate read/write word ports, little-endian 32-bit
// words, synchronous write, registered read, asynchronous active-high clear.
module memoria_32 #(
  parameter int DEPTH_BYTES = 256
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] raddress,
  input  logic [31:0] waddress,
  input  logic [31:0] Datain,
  input  logic        Wr,
  output logic [31:0] Dataout
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem_reg [DEPTH_BYTES];
  logic [31:0]   rdata_reg;
  logic [31:0]   rword;
  logic [AW-3:0] rword_idx;
  logic [AW-3:0] wword_idx;

  // Low two bits dropped for alignment, high bits dropped for wrap-around.
  assign rword_idx = raddress[AW-1:2];
  assign wword_idx = waddress[AW-1:2];

  // Gather the four little-endian bytes of the addressed read word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rlane
    assign rword[8*gi +: 8] = mem_reg[{rword_idx, 2'(gi)}];
  end

  // Clearing the whole array asynchronously rules out block RAM; storage is flops.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem_reg[i] <= 8'h00;
      end
    end else if (Wr) begin
      for (int k = 0; k < 4; k++) begin
        mem_reg[{wword_idx, k[1:0]}] <= Datain[8*k +: 8];
      end
    end
  end

  // Read samples the pre-write contents, giving read-before-write on collisions.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      rdata_reg <= 32'h0;
    end else begin
      rdata_reg <= rword;
    end
  end

  assign Dataout = rdata_reg;

endmodule

// File: tb/tb_memoria_32.sv
// Randomised self-checking bench for memoria_32 against a byte-array reference model.
module tb_memoria_32;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] raddress;
  logic [31:0] waddress;
  logic [31:0] Datain;
  logic        Wr;
  logic [31:0] Dataout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  model [DEPTH];
  logic [31:0] written_q [$];

  memoria_32 #(.DEPTH_BYTES(DEPTH)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .raddress (raddress),
    .waddress (waddress),
    .Datain   (Datain),
    .Wr       (Wr),
    .Dataout  (Dataout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  function automatic int base_of(input logic [31:0] a);
    return int'(a % DEPTH) / 4 * 4;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = base_of(a);
    return {model[b+3], model[b+2], model[b+1], model[b]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
  endtask

  // One clock cycle: drive, let the edge happen, update model, compare after the edge.
  task automatic step(input string tag, input logic wr, input logic [31:0] wa,
                      input logic [31:0] d, input logic [31:0] ra);
    logic [31:0] exp;
    int b;
    Wr = wr; waddress = wa; Datain = d; raddress = ra;
    @(posedge clk);
    exp = nrst ? 32'h0 : model_word(ra);
    if (wr && !nrst) begin
      b = base_of(wa);
      for (int k = 0; k < 4; k++) model[b+k] = d[8*k +: 8];
    end
    #1;
    check(tag, Dataout, exp);
  endtask

  initial begin
    model_clear();
    nrst = 1'b1; Wr = 1'b0; waddress = '0; raddress = '0; Datain = '0;
    #1;
    check("reset_state", Dataout, 32'h0);

    // Writes during reset must be ignored.
    for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 32'(4*i), 32'hA5A5A5A5, 32'(4*i));
    nrst = 1'b0;

    for (int a = 0; a <= 64; a += 4) step("sweep_zero", 1'b0, '0, '0, 32'(a));
    step("sweep_zero", 1'b0, '0, '0, 32'h0);

    step("wr8", 1'b1, 32'd8, 32'hDEADBEEF, 32'd0);
    step("wr12", 1'b1, 32'd12, 32'h01234567, 32'd0);
    written_q.push_back(32'd8);
    written_q.push_back(32'd12);
    step("rd8", 1'b0, '0, '0, 32'd8);
    check("byte8", {24'h0, Dataout[7:0]}, 32'h000000EF);
    step("rd12", 1'b0, '0, '0, 32'd12);
    check("rd12_const", Dataout, 32'h01234567);

    step("wr16", 1'b1, 32'd16, 32'h11111111, 32'd0);
    written_q.push_back(32'd16);
    step("rbw_old", 1'b1, 32'd16, 32'h22222222, 32'd16);
    check("rbw_old_const", Dataout, 32'h11111111);
    step("rbw_new", 1'b0, '0, '0, 32'd16);
    check("rbw_new_const", Dataout, 32'h22222222);

    step("align_0a", 1'b0, '0, '0, 32'h0A);
    check("align_0a_const", Dataout, 32'hDEADBEEF);
    step("wrap_108", 1'b0, '0, '0, 32'h108);
    check("wrap_108_const", Dataout, 32'hDEADBEEF);
    step("wr_100", 1'b1, 32'h100, 32'hCAFEF00D, 32'd4);
    written_q.push_back(32'd0);
    step("alias_0", 1'b0, '0, '0, 32'd0);
    check("alias_0_const", Dataout, 32'hCAFEF00D);

    step("wr0_guard", 1'b0, 32'd20, 32'hFFFFFFFF, 32'd0);
    step("rd20", 1'b0, '0, '0, 32'd20);
    check("rd20_const", Dataout, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic        wr;
      logic [31:0] wa, ra, d;
      wr = 1'($urandom_range(0, 1));
      wa = $urandom_range(0, 1023);
      ra = $urandom_range(0, 1023);
      d  = $urandom;
      if (wr) written_q.push_back(wa);
      step("random", wr, wa, d, ra);
    end

    step("pre_rst_wr", 1'b1, 32'd40, 32'h5A5A5A5A, 32'd0);
    written_q.push_back(32'd40);
    step("pre_rst_rd", 1'b0, '0, '0, 32'd40);
    // Assert reset between edges; output must clear without a clock.
    #2;
    nrst = 1'b1;
    #1;
    check("async_clear", Dataout, 32'h0);
    model_clear();
    step("rst_held", 1'b1, 32'd40, 32'h77777777, 32'd40);
    nrst = 1'b0;
    foreach (written_q[i]) step("post_rst_zero", 1'b0, '0, '0, written_q[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
